fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the five-stage pipeline. It owns the program counter and drives PCout into the byte-addressed, big-endian instruction memory, which returns IMout combinationally. It registers the fetched word into the IF/ID pipeline register and handles hazard-unit stalls and branch/jump redirects. It stops fetching at the end of the program image and traps misaligned redirect targets.

---
 rtl/fetch_ctrl_if.sv | 29 ++
 rtl/fetch_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus between the PC/IF-ID sequencer and its environment.
// The sequencer takes the slave modport; the master side drives hazards, redirects and memory data.
interface fetch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             stall;
   logic             branch_taken;
   logic [31:0]      branch_target;
   logic             jump;
   logic [31:0]      jump_target;
   logic [31:0]      IMout;
   logic [31:0]      PCout;
   logic [31:0]      IFID_instr;
   logic [31:0]      IFID_pc4;
   logic             IFID_valid;
   logic             halted;
   logic             misalign_err;
   logic [CNT_W-1:0] fetch_count;

   modport master (
      output stall, branch_taken, branch_target, jump, jump_target, IMout,
      input  PCout, IFID_instr, IFID_pc4, IFID_valid, halted, misalign_err, fetch_count
   );

   modport slave (
      input  stall, branch_taken, branch_target, jump, jump_target, IMout,
      output PCout, IFID_instr, IFID_pc4, IFID_valid, halted, misalign_err, fetch_count
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and registers IMout into IF/ID one cycle after PCout.
// Stall holds PC and IF/ID; redirects override stall and flush IF; a misaligned target locks ERROR until reset.
module fetch_ctrl #(
   parameter int          IMEM_BYTES = 40,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          CNT_W      = 16
) (
   input  logic          clk,
   input  logic          reset,
   fetch_ctrl_if.slave   bus
);
   localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HALT  = 2'd1,
      ERROR = 2'd2
   } state_t;

   state_t           r_state, w_state_n;
   logic [31:0]      r_pc, w_pc_n;
   logic [31:0]      r_instr, w_instr_n;
   logic [31:0]      r_pc4, w_pc4_n;
   logic             r_valid, w_valid_n;
   logic             r_halted;
   logic             r_err, w_err_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;

   logic [31:0]      w_seq_pc;
   logic             w_redir;
   logic [31:0]      w_tgt;
   logic             w_tgt_mis;
   logic             w_tgt_oob;

   // Branch outranks jump: it belongs to the older instruction in EX.
   assign w_seq_pc  = r_pc + 32'd4;
   assign w_redir   = bus.branch_taken | bus.jump;
   assign w_tgt     = bus.branch_taken ? bus.branch_target : bus.jump_target;
   assign w_tgt_mis = |w_tgt[1:0];
   assign w_tgt_oob = w_tgt > LAST_PC;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= FETCH;
         r_pc     <= RESET_PC;
         r_instr  <= 32'd0;
         r_pc4    <= 32'd0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_n;
         r_pc     <= w_pc_n;
         r_instr  <= w_instr_n;
         r_pc4    <= w_pc4_n;
         r_valid  <= w_valid_n;
         r_halted <= (w_state_n == HALT);
         r_err    <= w_err_n;
         r_cnt    <= w_cnt_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_pc_n    = r_pc;
      w_instr_n = r_instr;
      w_pc4_n   = r_pc4;
      w_valid_n = r_valid;
      w_err_n   = r_err;
      w_cnt_n   = r_cnt;

      case (r_state)
         FETCH, HALT: begin
            if (w_redir) begin
               w_valid_n = 1'b0;
               if (w_tgt_mis) begin
                  w_state_n = ERROR;
                  w_err_n   = 1'b1;
               end else begin
                  w_pc_n    = w_tgt;
                  w_state_n = w_tgt_oob ? HALT : FETCH;
               end
            end else if (r_state == HALT) begin
               // Past the image: IMout is meaningless here, so nothing is captured.
               w_valid_n = 1'b0;
            end else if (!bus.stall) begin
               w_instr_n = bus.IMout;
               w_pc4_n   = w_seq_pc;
               w_valid_n = 1'b1;
               w_cnt_n   = r_cnt + 1'b1;
               w_pc_n    = w_seq_pc;
               w_state_n = (w_seq_pc > LAST_PC) ? HALT : FETCH;
            end
         end
         ERROR: begin
            w_valid_n = 1'b0;
         end
         default: begin
            w_state_n = ERROR;
            w_valid_n = 1'b0;
            w_err_n   = 1'b1;
         end
      endcase
   end

   assign bus.PCout        = r_pc;
   assign bus.IFID_instr   = r_instr;
   assign bus.IFID_pc4     = r_pc4;
   assign bus.IFID_valid   = r_valid;
   assign bus.halted       = r_halted;
   assign bus.misalign_err = r_err;
   assign bus.fetch_count  = r_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl against a 10-word big-endian instruction image.
module tb_fetch_ctrl;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   logic [31:0] imem [0:9];

   fetch_ctrl_if #(.CNT_W(16)) bus ();

   fetch_ctrl #(
      .IMEM_BYTES (40),
      .RESET_PC   (32'h0000_0000),
      .CNT_W      (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.IMout = (bus.PCout < 32'd40) ? imem[bus.PCout[5:2]] : 32'hDEAD_BEEF;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'd0;
      bus.jump          = 1'b0;
      bus.jump_target   = 32'd0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"},    bus.PCout, 32'd0);
      chk({tag, "_instr"}, bus.IFID_instr, 32'd0);
      chk({tag, "_pc4"},   bus.IFID_pc4, 32'd0);
      chk({tag, "_valid"}, {31'd0, bus.IFID_valid}, 32'd0);
      chk({tag, "_halt"},  {31'd0, bus.halted}, 32'd0);
      chk({tag, "_err"},   {31'd0, bus.misalign_err}, 32'd0);
      chk({tag, "_cnt"},   {16'd0, bus.fetch_count}, 32'd0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      imem[0] = 32'h8C05_0000;
      imem[1] = 32'h8C0A_0004;
      imem[2] = 32'h00AA_6820;
      imem[3] = 32'h00AA_6825;
      imem[4] = 32'h00AA_6822;
      imem[5] = 32'hAC0D_0010;
      imem[6] = 32'hAC0E_0014;
      imem[7] = 32'h1000_FFFF;
      imem[8] = 32'h0000_0020;
      imem[9] = 32'h0800_0000;
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      chk_reset_vals("rst");

      // 1: straight-line fetch through the whole image
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("seq%0d_pc", i),    bus.PCout, 32'((i + 1) * 4));
         chk($sformatf("seq%0d_instr", i), bus.IFID_instr, imem[i]);
         chk($sformatf("seq%0d_pc4", i),   bus.IFID_pc4, 32'((i + 1) * 4));
         chk($sformatf("seq%0d_valid", i), {31'd0, bus.IFID_valid}, 32'd1);
         chk($sformatf("seq%0d_cnt", i),   {16'd0, bus.fetch_count}, 32'(i + 1));
      end
      chk("seq_end_halt", {31'd0, bus.halted}, 32'd1);
      bus.stall = 1'b1;
      step();
      chk("halt_valid", {31'd0, bus.IFID_valid}, 32'd0);
      chk("halt_halted", {31'd0, bus.halted}, 32'd1);
      chk("halt_pc", bus.PCout, 32'd40);
      chk("halt_cnt", {16'd0, bus.fetch_count}, 32'd10);
      bus.stall = 1'b0;

      // 2: stall at PC 8
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      step();
      chk("pre_stall_pc", bus.PCout, 32'd8);
      bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("stall%0d_pc", i),    bus.PCout, 32'd8);
         chk($sformatf("stall%0d_instr", i), bus.IFID_instr, 32'h8C0A_0004);
         chk($sformatf("stall%0d_valid", i), {31'd0, bus.IFID_valid}, 32'd1);
         chk($sformatf("stall%0d_cnt", i),   {16'd0, bus.fetch_count}, 32'd2);
      end
      bus.stall = 1'b0;
      step();
      chk("unstall_instr", bus.IFID_instr, 32'h00AA_6820);
      chk("unstall_pc", bus.PCout, 32'd12);
      chk("unstall_cnt", {16'd0, bus.fetch_count}, 32'd3);

      // 3: branch + jump + stall together at PC 12
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h14;
      bus.jump          = 1'b1;
      bus.jump_target   = 32'h20;
      bus.stall         = 1'b1;
      step();
      chk("redir_pc", bus.PCout, 32'd20);
      chk("redir_valid", {31'd0, bus.IFID_valid}, 32'd0);
      chk("redir_cnt", {16'd0, bus.fetch_count}, 32'd3);
      idle_inputs();
      step();
      chk("post_redir_instr", bus.IFID_instr, 32'hAC0D_0010);
      chk("post_redir_pc4", bus.IFID_pc4, 32'd24);
      chk("post_redir_valid", {31'd0, bus.IFID_valid}, 32'd1);
      chk("post_redir_cnt", {16'd0, bus.fetch_count}, 32'd4);

      // 4: run to HALT, then jump back into the image
      for (int i = 0; i < 4; i++) step();
      chk("h2_pc", bus.PCout, 32'd40);
      chk("h2_halted", {31'd0, bus.halted}, 32'd1);
      step();
      chk("h2_valid", {31'd0, bus.IFID_valid}, 32'd0);
      bus.jump        = 1'b1;
      bus.jump_target = 32'h10;
      step();
      chk("resume_pc", bus.PCout, 32'd16);
      chk("resume_halted", {31'd0, bus.halted}, 32'd0);
      idle_inputs();
      step();
      chk("resume_instr", bus.IFID_instr, 32'h00AA_6822);
      chk("resume_valid", {31'd0, bus.IFID_valid}, 32'd1);
      chk("resume_cnt", {16'd0, bus.fetch_count}, 32'd9);

      // 5: misaligned branch target, then ERROR ignores redirects
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h06;
      step();
      chk("mis_err", {31'd0, bus.misalign_err}, 32'd1);
      chk("mis_valid", {31'd0, bus.IFID_valid}, 32'd0);
      chk("mis_pc", bus.PCout, 32'd20);
      chk("mis_halted", {31'd0, bus.halted}, 32'd0);
      bus.branch_target = 32'h04;
      step();
      chk("err_br_pc", bus.PCout, 32'd20);
      idle_inputs();
      bus.jump        = 1'b1;
      bus.jump_target = 32'h04;
      step();
      chk("err_j_pc", bus.PCout, 32'd20);
      chk("err_j_err", {31'd0, bus.misalign_err}, 32'd1);
      chk("err_j_cnt", {16'd0, bus.fetch_count}, 32'd9);
      idle_inputs();
      step();
      chk("err_idle_pc", bus.PCout, 32'd20);
      chk("err_idle_valid", {31'd0, bus.IFID_valid}, 32'd0);

      // 6: reset clears ERROR; then reset during stall + branch at PC 24
      reset = 1'b1;
      step();
      chk_reset_vals("rst_err");
      reset = 1'b0;
      bus.jump        = 1'b1;
      bus.jump_target = 32'h18;
      step();
      chk("j24_pc", bus.PCout, 32'd24);
      idle_inputs();
      bus.stall = 1'b1;
      step();
      chk("s24_pc", bus.PCout, 32'd24);
      reset             = 1'b1;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h10;
      step();
      chk_reset_vals("rst_mid");
      reset = 1'b0;
      idle_inputs();

      // aligned redirect beyond the image lands in HALT
      bus.jump        = 1'b1;
      bus.jump_target = 32'h100;
      step();
      chk("oob_pc", bus.PCout, 32'h100);
      chk("oob_halted", {31'd0, bus.halted}, 32'd1);
      chk("oob_valid", {31'd0, bus.IFID_valid}, 32'd0);
      idle_inputs();
      step();
      chk("oob_hold_pc", bus.PCout, 32'h100);
      chk("oob_hold_cnt", {16'd0, bus.fetch_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
